ct_stream_ctrl: RTL and testbench

- Read-out sequencer for the ciphertext memory after encryption finishes.
- Requests the shared single-port ct memory and reads every m*DIGIT-bit word in address order.
- Serializes each word into 32-bit beats on a valid/ready stream, LSB beat first.
- Sits beside the encryption controller and the GF(2^m)[z] multiplier on an OR-combined memory bus.
- Drives all memory-side outputs to zero whenever it does not own the port.

---
 rtl/ct_stream_ctrl_pkg.sv | 29 ++
 rtl/ct_stream_ctrl_word_serializer.sv | 44 ++++
 rtl/ct_stream_ctrl.sv | 112 +++++++++++
 tb/tb_ct_stream_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_stream_ctrl_pkg.sv
// Shared sizes and state encoding for the ciphertext read-out sequencer.
// Word, depth and beat counts are derived from the code/field parameters.
package ct_stream_ctrl_pkg;

  localparam int N     = 47;
  localparam int M     = 79;
  localparam int DIGIT = 4;
  localparam int OUT_W = 32;

  localparam int WORD_W  = M * DIGIT;
  localparam int DEPTH   = (N + DIGIT - 1) / DIGIT;
  localparam int BEATS   = (WORD_W + OUT_W - 1) / OUT_W;
  localparam int SHREG_W = BEATS * OUT_W;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int BCNT_W  = $clog2(BEATS);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RD,
    ST_CAP,
    ST_EMIT,
    ST_FIN
  } state_e;

endpackage

// File: rtl/ct_stream_ctrl_word_serializer.sv
// Parallel-load word register that shifts out OUT_W-bit beats, LSB beat first.
// last_beat flags the final beat of the word so the controller can advance.
module ct_stream_ctrl_word_serializer
  import ct_stream_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_b,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift,
  output logic [OUT_W-1:0]  beat,
  output logic              last_beat
);

  logic [SHREG_W-1:0] shreg_q, shreg_d;
  logic [BCNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  assign beat      = shreg_q[OUT_W-1:0];
  assign last_beat = (beat_cnt_q == LAST_BEAT);

  always_comb begin
    shreg_d    = shreg_q;
    beat_cnt_d = beat_cnt_q;
    if (load) begin
      shreg_d    = SHREG_W'(load_data);
      beat_cnt_d = '0;
    end else if (shift) begin
      shreg_d = shreg_q >> OUT_W;
      // Counter parks on the last beat; the controller reloads for the next word.
      if (!last_beat) beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      shreg_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      shreg_q    <= shreg_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: rtl/ct_stream_ctrl.sv
// Ciphertext memory read-out sequencer: requests the shared ct port, reads
// each word in address order and streams it as valid/ready beats.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | requesting the ct port, waiting for grant
// RD    | address driven, memory read in flight
// CAP   | read data captured into the serializer
// EMIT  | beats presented on the stream
// FIN   | one-cycle done pulse, return to IDLE
module ct_stream_ctrl
  import ct_stream_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  input  logic [WORD_W-1:0] mem_dout,
  output logic [OUT_W-1:0]  data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic              ser_load;
  logic              ser_shift;
  logic              last_beat;

  ct_stream_ctrl_word_serializer u_ser (
    .clk       (clk),
    .rst_b     (rst_b),
    .load      (ser_load),
    .load_data (mem_dout),
    .shift     (ser_shift),
    .beat      (data_out),
    .last_beat (last_beat)
  );

  assign mem_rw = 1'b0;
  assign busy   = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    mem_req    = 1'b0;
    mem_addr   = '0;
    data_valid = 1'b0;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        word_idx_d = '0;
        if (start) state_d = ST_REQ;
      end
      ST_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = ST_RD;
      end
      ST_RD: begin
        mem_req  = 1'b1;
        mem_addr = word_idx_q;
        state_d  = ST_CAP;
      end
      ST_CAP: begin
        mem_req  = 1'b1;
        mem_addr = word_idx_q;
        ser_load = 1'b1;
        state_d  = ST_EMIT;
      end
      ST_EMIT: begin
        mem_req    = 1'b1;
        data_valid = 1'b1;
        if (data_ready) begin
          ser_shift = 1'b1;
          if (last_beat) begin
            if (word_idx_q == LAST_WORD) begin
              state_d = ST_FIN;
            end else begin
              word_idx_d = word_idx_q + 1'b1;
              // Grant is re-sampled only at word boundaries.
              state_d    = mem_gnt ? ST_RD : ST_REQ;
            end
          end
        end
      end
      ST_FIN: begin
        done       = 1'b1;
        word_idx_d = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
    end
  end

endmodule

// File: tb/tb_ct_stream_ctrl.sv
// Directed bench for ct_stream_ctrl with a beat scoreboard fed from a memory model.
module tb_ct_stream_ctrl;
  import ct_stream_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst_b;
  logic              start;
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rw;
  logic [WORD_W-1:0] mem_dout;
  logic [OUT_W-1:0]  data_out;
  logic              data_valid;
  logic              data_ready;
  logic              busy;
  logic              done;

  ct_stream_ctrl dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .start      (start),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_addr   (mem_addr),
    .mem_rw     (mem_rw),
    .mem_dout   (mem_dout),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [WORD_W-1:0] mem [16];
  always @(posedge clk) mem_dout <= mem[mem_addr];

  int          checks = 0;
  int          errors = 0;
  int          ncyc = 0;
  int          beats = 0;
  int          done_cnt = 0;
  int          first_valid_n = -1;
  int          done_n = -1;
  logic        stall_prev = 1'b0;
  logic [31:0] held = '0;
  logic [31:0] sb [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: advance to the falling edge and run the stream monitor there.
  task step;
    logic [31:0] exp;
    @(negedge clk);
    ncyc++;
    if (stall_prev && data_valid) chk("hold_during_stall", 64'(data_out), 64'(held));
    if (data_valid && data_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 64'(1), 64'(0));
      end else begin
        exp = sb.pop_front();
        chk("beat_data", 64'(data_out), 64'(exp));
      end
      beats++;
    end
    if (data_valid && first_valid_n < 0) first_valid_n = ncyc;
    stall_prev = data_valid && !data_ready;
    held       = data_out;
    if (done) begin
      done_cnt++;
      done_n = ncyc;
    end
  endtask

  task push_all;
    logic [SHREG_W-1:0] ext;
    for (int k = 0; k < DEPTH; k++) begin
      ext = SHREG_W'(mem[k]);
      for (int j = 0; j < BEATS; j++) sb.push_back(ext[32*j +: 32]);
    end
  endtask

  task pulse_start;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task wait_done(input string tag, input int limit, input int d0, input bit tog);
    int n;
    n = 0;
    while (done_cnt == d0 && n < limit) begin
      step();
      if (tog) data_ready = ~data_ready;
      n++;
    end
    data_ready = 1'b1;
    chk({tag, "_done_seen"}, 64'(done_cnt - d0), 64'(1));
  endtask

  task wait_beats(input int target, input int limit);
    int n;
    n = 0;
    while (beats < target && n < limit) begin
      step();
      n++;
    end
    chk("beat_wait", 64'(beats >= target), 64'(1));
  endtask

  initial begin
    logic [319:0] pat;
    int s, d0, b0, g;

    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 20; i++) pat[16*i +: 16] = 16'(k);
      mem[k] = (k < DEPTH) ? pat[WORD_W-1:0] : '0;
    end

    rst_b      = 1'b1;
    start      = 1'b0;
    mem_gnt    = 1'b1;
    data_ready = 1'b1;
    repeat (3) step();
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_rw", 64'(mem_rw), 64'(0));
    chk("rst_data_out", 64'(data_out), 64'(0));
    chk("rst_data_valid", 64'(data_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    rst_b = 1'b0;
    repeat (2) step();

    // Full-throughput transfer
    b0 = beats; d0 = done_cnt; first_valid_n = -1;
    push_all();
    s = ncyc;
    pulse_start();
    chk("t1_busy", 64'(busy), 64'(1));
    wait_done("t1", 400, d0, 1'b0);
    chk("t1_first_valid_lat", 64'(first_valid_n - s), 64'(4));
    chk("t1_done_lat", 64'(done_n - s), 64'(146));
    chk("t1_beats", 64'(beats - b0), 64'(120));
    chk("t1_sb_empty", 64'(sb.size()), 64'(0));
    step();
    chk("t1_idle_busy", 64'(busy), 64'(0));

    // Ready toggling every cycle
    b0 = beats; d0 = done_cnt;
    push_all();
    pulse_start();
    wait_done("t2", 800, d0, 1'b1);
    chk("t2_beats", 64'(beats - b0), 64'(120));
    chk("t2_sb_empty", 64'(sb.size()), 64'(0));
    repeat (2) step();

    // Grant withheld for 20 cycles after start
    b0 = beats; d0 = done_cnt; first_valid_n = -1;
    push_all();
    mem_gnt = 1'b0;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      chk("t3_req_wait", 64'(mem_req), 64'(1));
      chk("t3_addr_wait", 64'(mem_addr), 64'(0));
      step();
    end
    mem_gnt = 1'b1;
    g = ncyc;
    wait_done("t3", 400, d0, 1'b0);
    chk("t3_first_valid_lat", 64'(first_valid_n - g), 64'(3));
    chk("t3_beats", 64'(beats - b0), 64'(120));
    repeat (2) step();

    // Grant dropped at the boundary after word 5
    b0 = beats; d0 = done_cnt;
    push_all();
    pulse_start();
    wait_beats(b0 + 60, 300);
    mem_gnt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_req_hold", 64'(mem_req), 64'(1));
      chk("t4_addr_zero", 64'(mem_addr), 64'(0));
      chk("t4_no_valid", 64'(data_valid), 64'(0));
    end
    mem_gnt = 1'b1;
    step();
    chk("t4_resume_addr", 64'(mem_addr), 64'(6));
    wait_done("t4", 400, d0, 1'b0);
    chk("t4_beats", 64'(beats - b0), 64'(120));
    repeat (2) step();

    // Reset asserted mid-stream in word 3
    b0 = beats; d0 = done_cnt;
    push_all();
    pulse_start();
    wait_beats(b0 + 35, 300);
    rst_b = 1'b1;
    #1;
    chk("t5_req", 64'(mem_req), 64'(0));
    chk("t5_addr", 64'(mem_addr), 64'(0));
    chk("t5_valid", 64'(data_valid), 64'(0));
    chk("t5_data", 64'(data_out), 64'(0));
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_done", 64'(done), 64'(0));
    sb.delete();
    stall_prev = 1'b0;
    repeat (2) step();
    rst_b = 1'b0;
    repeat (5) step();
    chk("t5_no_done", 64'(done_cnt - d0), 64'(0));
    b0 = beats;
    push_all();
    pulse_start();
    step();
    chk("t5_restart_addr", 64'(mem_addr), 64'(0));
    wait_done("t5", 400, d0, 1'b0);
    chk("t5_beats", 64'(beats - b0), 64'(120));
    repeat (2) step();

    // Second start while busy is ignored
    b0 = beats; d0 = done_cnt;
    push_all();
    pulse_start();
    repeat (20) step();
    pulse_start();
    wait_done("t6", 400, d0, 1'b0);
    repeat (200) step();
    chk("t6_single_done", 64'(done_cnt - d0), 64'(1));
    chk("t6_beats", 64'(beats - b0), 64'(120));
    chk("t6_idle", 64'(busy), 64'(0));
    chk("t6_sb_empty", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
